sha256_compress: RTL and testbench
==================================

Name: sha256_compress

Overview:
- Downstream neighbour of the SHA-256 padder. Consumes padded 512-bit message blocks and runs the 64-round SHA-256 compression, one round per cycle.
- Accumulates the hash state across blocks and emits the 256-bit digest after the block flagged last.
- Feeds the PBKDF2/HMAC control logic, which consumes digests through a valid/ready handshake.

Parameters:
- ROUNDS, 64, number of compression rounds. Fixed by the standard; exists only for bench visibility and must not be overridden.

Ports:
- clk_i  input  1  clock; all logic on posedge
- rst_i  input  1  synchronous active-high reset
- in_valid  input  1  in/in_first/in_last valid
- in  input  512  padded block; W0 = in[511:480], W15 = in[31:0] (big-endian words)
- in_first  input  1  block starts a new message; load IV before compressing
- in_last  input  1  block ends the message; emit digest after it
- in_ready  output  1  block accepted when in_valid && in_ready
- out_valid  output  1  digest valid
- out  output  256  digest; H0 = out[255:224] ... H7 = out[31:0]
- out_ready  input  1  consumer accepts digest when out_valid && out_ready

Behaviour:
- Reset (rst_i high at posedge):
  - state=IDLE, in_ready=1, out_valid=0, out=0, round counter=0.
  - H0..H7 = IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19).
  - Reset anywhere, including mid-round or in DONE, aborts all work; no digest is produced for an aborted message.
- States: IDLE, ROUND, UPDATE, DONE.
- IDLE, in_ready=1:
  - On handshake, latch block into a 16x32 schedule window W.
  - Initialise working vars a..h: from IV if in_first=1, else from current H.
  - If in_first=1, also load H=IV in the same cycle.
  - Latch in_last. Clear counter t=0. in_ready<=0. Go to ROUND.
- ROUND, t=0..63:
  - Per cycle: T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + W[0]; T2 = Σ0(a) + Maj(a,b,c).
  - Rotate a..h per the standard.
  - Shift W left one word; append σ1(W[14]) + W[9] + σ0(W[1]) + W[0].
  - All additions are mod 2^32; carries are discarded.
  - K is a 64-entry constant ROM indexed by t.
  - At t=63 go to UPDATE; otherwise t<=t+1.
- UPDATE (1 cycle): Hi <= Hi + working var i, mod 2^32.
  - If last flag = 0: in_ready<=1, go to IDLE.
  - If last flag = 1: out <= updated H (not the stale H); out_valid<=1; reload H=IV; go to DONE.
- DONE:
  - out_valid held 1 and out held stable until out_ready=1.
  - On that cycle: out_valid<=0, in_ready<=1, go to IDLE.
  - in_ready=0 throughout DONE, so no block is accepted while a digest is pending.
- Latency:
  - Handshake at cycle N; rounds occupy N+1..N+64; UPDATE at N+65; out_valid visible from N+66.
  - Non-last block: in_ready high again from N+66.
  - Per-block throughput: 66 cycles.
- Boundary conditions:
  - in_valid with in_ready=0 is ignored. Upstream holds data; nothing is sampled.
  - in_first and in_last both 1: a single-block message, valid.
  - in_first=0 on the first block after reset or after a digest: H is already IV, so the result is identical to in_first=1.
  - out_ready high before out_valid: no effect.
  - out_ready and out_valid high in the same cycle: digest consumed in that cycle.
  - Inputs not sampled while the handshake is not occurring.

Test Plan:
- Single block "abc" (in = 61626380 followed by 0s, last word 00000018), first=last=1 -> out = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, out_valid rising exactly 66 cycles after the handshake.
- Empty message (in = 80000000 followed by 0s, length word 0), first=last=1 -> out = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Two-block 448-bit "abcdbcdecdefdefg...nopq" message: block 1 first=1/last=0, block 2 first=0/last=1 -> out = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1; out_valid=0 after block 1.
- Backpressure: out_ready held low 20 cycles after "abc" digest -> out_valid and out stable; in_ready=0 and an offered block is not taken; accepted one cycle after out_ready=1.
- Reset at round t=30 of block 1 of the two-block message, then replay "abc" -> "abc" digest exact, with no stale out_valid.
- Back-to-back messages: "abc" then empty message, consumer always ready -> both digests correct, proving IV reload between messages.

Source files
------------

// File: rtl/sha256_compress.sv
// sha256_compress: SHA-256 compression core, one round per clock.
// Hash state is accumulated across the blocks of a message; the digest is
// presented on a valid/ready port after the block flagged last.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   S_IDLE   | in_ready high, waiting for a padded block
//   S_ROUND  | 64 compression rounds, t_q = current round
//   S_UPDATE | fold working variables into H, emit digest if last block
//   S_DONE   | digest held on out until the consumer takes it
module sha256_compress #(
    parameter int ROUNDS = 64
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid,
    input  logic [511:0] in,
    input  logic         in_first,
    input  logic         in_last,
    output logic         in_ready,
    output logic         out_valid,
    output logic [255:0] out,
    input  logic         out_ready
);
    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_UPDATE, S_DONE} state_t;

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    state_t       state_q;
    logic [5:0]   t_q;
    logic [31:0]  w_q [16];   // sliding schedule window, w_q[0] = W[t]
    logic [31:0]  v_q [8];    // working variables a..h
    logic [31:0]  h_q [8];    // chaining hash H0..H7
    logic         last_q;
    logic         in_ready_q;
    logic         out_valid_q;
    logic [255:0] out_q;

    logic [31:0]  t1_d;
    logic [31:0]  t2_d;
    logic [31:0]  w_new_d;
    logic [31:0]  hsum_d [8];

    // Round datapath: T1/T2, next schedule word and the end-of-block hash sum
    always_comb begin
        t1_d    = v_q[7] + bsig1(v_q[4]) + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6]))
                + K[t_q] + w_q[0];
        t2_d    = bsig0(v_q[0]) + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));
        w_new_d = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];
        for (int i = 0; i < 8; i++) begin
            hsum_d[i] = h_q[i] + v_q[i];
        end
    end

    // Control FSM with the schedule, working variables and hash registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            t_q         <= '0;
            last_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            for (int i = 0; i < 16; i++) w_q[i] <= '0;
            for (int i = 0; i < 8; i++) begin
                v_q[i] <= '0;
                h_q[i] <= IV[i];
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        for (int i = 0; i < 16; i++) w_q[i] <= in[511 - 32*i -: 32];
                        for (int i = 0; i < 8; i++) begin
                            v_q[i] <= in_first ? IV[i] : h_q[i];
                            if (in_first) h_q[i] <= IV[i];
                        end
                        last_q     <= in_last;
                        t_q        <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    v_q[0] <= t1_d + t2_d;
                    v_q[1] <= v_q[0];
                    v_q[2] <= v_q[1];
                    v_q[3] <= v_q[2];
                    v_q[4] <= v_q[3] + t1_d;
                    v_q[5] <= v_q[4];
                    v_q[6] <= v_q[5];
                    v_q[7] <= v_q[6];
                    for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
                    w_q[15] <= w_new_d;
                    if (t_q == 6'(ROUNDS - 1)) state_q <= S_UPDATE;
                    else                       t_q     <= t_q + 6'd1;
                end
                S_UPDATE: begin
                    if (last_q) begin
                        // digest is taken from the freshly summed H; H restarts at IV
                        for (int i = 0; i < 8; i++) begin
                            out_q[255 - 32*i -: 32] <= hsum_d[i];
                            h_q[i] <= IV[i];
                        end
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        for (int i = 0; i < 8; i++) h_q[i] <= hsum_d[i];
                        in_ready_q <= 1'b1;
                        state_q    <= S_IDLE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out       = out_q;

endmodule

// File: tb/tb_sha256_compress.sv
// tb_sha256_compress: scoreboard bench for sha256_compress. Directed
// vectors plus random multi-block messages checked against a plain
// FIPS-style SHA-256 compression model.
module tb_sha256_compress;
    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         in_valid;
    logic [511:0] in_blk;
    logic         in_first;
    logic         in_last;
    logic         in_ready;
    logic         out_valid;
    logic [255:0] out_dig;
    logic         out_ready;

    always #5 clk_i = ~clk_i;

    sha256_compress dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .in_valid (in_valid),
        .in       (in_blk),
        .in_first (in_first),
        .in_last  (in_last),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out      (out_dig),
        .out_ready(out_ready)
    );

    localparam logic [255:0] IV256 =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
    localparam logic [511:0] TWO_B1 = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] TWO_B2 = {480'h0, 32'h000001c0};
    localparam logic [255:0] ABC_D =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMPTY_D =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] TWO_D =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    int           last_hs_cyc = 0;
    int           ready_ctl = 0;     // 2 = random consumer, otherwise driven directly
    logic [255:0] exp_q [$];
    logic [255:0] model_h = IV256;

    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Whole-message-schedule SHA-256 compression of one block
    function automatic logic [255:0] ref_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] hv [8];
        logic [31:0] x [8];
        logic [31:0] t1, t2, s0, s1;
        logic [255:0] r;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        for (int i = 0; i < 8; i++) begin
            hv[i] = hin[255 - 32*i -: 32];
            x[i]  = hv[i];
        end
        for (int t = 0; t < 64; t++) begin
            t1 = x[7] + (rr(x[4], 6) ^ rr(x[4], 11) ^ rr(x[4], 25))
               + ((x[4] & x[5]) ^ (~x[4] & x[6])) + KT[t] + w[t];
            t2 = (rr(x[0], 2) ^ rr(x[0], 13) ^ rr(x[0], 22))
               + ((x[0] & x[1]) ^ (x[0] & x[2]) ^ (x[1] & x[2]));
            for (int j = 7; j > 0; j--) x[j] = x[j-1];
            x[4] = x[4] + t1;
            x[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hv[i] + x[i];
        return r;
    endfunction

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[511 - 32*i -: 32] = $urandom();
        return b;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: wait bound expired, event required", name);
    endtask

    // Record a handshake happening at the coming posedge and update the model
    task automatic accept(input logic [511:0] blk, input logic first, input logic last,
                          input bit use_exp, input logic [255:0] exp);
        last_hs_cyc = cyc + 1;
        if (first) model_h = IV256;
        model_h = ref_compress(model_h, blk);
        if (last) begin
            exp_q.push_back(use_exp ? exp : model_h);
            model_h = IV256;
        end
    endtask

    // Offer a block (entered at a negedge) and hold it until accepted
    task automatic send(input logic [511:0] blk, input logic first, input logic last,
                        input bit use_exp, input logic [255:0] exp);
        int n = 0;
        in_blk = blk; in_first = first; in_last = last; in_valid = 1'b1;
        while (!in_ready && n < 3000) begin
            @(negedge clk_i);
            n++;
        end
        if (!in_ready) begin
            timeout_fail("send_in_ready");
            in_valid = 1'b0;
            return;
        end
        accept(blk, first, last, use_exp, exp);
        @(negedge clk_i);
        in_valid = 1'b0;
        in_blk   = rand_block();
        in_first = 1'($urandom_range(0, 1));
        in_last  = 1'($urandom_range(0, 1));
    endtask

    // Random consumer
    initial forever begin
        @(negedge clk_i);
        if (ready_ctl == 2) out_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: digest latency, hold stability under backpressure, scoreboard pop
    initial begin
        logic         prev_valid = 1'b0;
        logic         prev_taken = 1'b0;
        logic [255:0] prev_out = '0;
        logic [255:0] e;
        forever begin
            @(negedge clk_i);
            #1;
            if (rst_i) begin
                prev_valid = 1'b0;
            end else begin
                if (out_valid) begin
                    if (!prev_valid || prev_taken)
                        chk("digest_latency", 256'((cyc + 1) - last_hs_cyc), 256'd66);
                    else
                        chk("digest_hold", out_dig, prev_out);
                    if (out_ready) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL digest_unexpected: got %h, expected no digest", out_dig);
                        end else begin
                            e = exp_q.pop_front();
                            chk("digest", out_dig, e);
                        end
                    end
                end
                prev_valid = out_valid;
                prev_taken = out_ready;
                prev_out   = out_dig;
            end
        end
    end

    initial begin
        int n;
        rst_i = 1'b1; in_valid = 1'b0; in_blk = '0; in_first = 1'b0; in_last = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("reset_in_ready", 256'(in_ready), 256'd1);
        chk("reset_out_valid", 256'(out_valid), 256'd0);
        chk("reset_out", out_dig, 256'd0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // "abc" then empty message back to back, consumer always ready
        out_ready = 1'b1;
        send(ABC_BLK, 1'b1, 1'b1, 1'b1, ABC_D);
        send(EMPTY_BLK, 1'b1, 1'b1, 1'b1, EMPTY_D);

        // two-block message: no digest after block 1, in_ready back after 66 cycles
        send(TWO_B1, 1'b1, 1'b0, 1'b1, '0);
        n = 0;
        while (!in_ready && n < 200) begin @(negedge clk_i); n++; end
        if (!in_ready) timeout_fail("blk1_in_ready");
        chk("blk1_ready_latency", 256'((cyc + 1) - last_hs_cyc), 256'd66);
        chk("blk1_no_out_valid", 256'(out_valid), 256'd0);
        send(TWO_B2, 1'b0, 1'b1, 1'b1, TWO_D);

        // backpressure: digest held, offered block refused until consumed
        n = 0;
        while (!in_ready && n < 200) begin @(negedge clk_i); n++; end
        out_ready = 1'b0;
        send(ABC_BLK, 1'b1, 1'b1, 1'b1, ABC_D);
        n = 0;
        while (!out_valid && n < 200) begin @(negedge clk_i); n++; end
        if (!out_valid) timeout_fail("bp_out_valid");
        in_blk = EMPTY_BLK; in_first = 1'b1; in_last = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            chk("bp_in_ready_low", 256'(in_ready), 256'd0);
            chk("bp_out_valid_high", 256'(out_valid), 256'd1);
        end
        out_ready = 1'b1;
        @(negedge clk_i);
        chk("bp_accept_next", 256'(in_ready), 256'd1);
        accept(EMPTY_BLK, 1'b1, 1'b1, 1'b1, EMPTY_D);
        @(negedge clk_i);
        in_valid = 1'b0;

        // reset at round 30 of a block, then "abc" with in_first=0
        n = 0;
        while (!in_ready && n < 200) begin @(negedge clk_i); n++; end
        send(TWO_B1, 1'b1, 1'b0, 1'b1, '0);
        repeat (30) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        model_h = IV256;
        chk("abort_out_valid", 256'(out_valid), 256'd0);
        chk("abort_in_ready", 256'(in_ready), 256'd1);
        chk("abort_out", out_dig, 256'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        send(ABC_BLK, 1'b0, 1'b1, 1'b1, ABC_D);

        // random multi-block messages with a random consumer
        ready_ctl = 2;
        for (int m = 0; m < 12; m++) begin
            int nb;
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk_i);
                send(rand_block(), (b == 0) ? 1'($urandom_range(0, 1)) : 1'b0,
                     (b == nb - 1), 1'b0, '0);
            end
        end

        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin @(negedge clk_i); n++; end
        if (exp_q.size() != 0) timeout_fail("drain");
        ready_ctl = 0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
